// File: rtl/apb_cmd_master.sv
// APB initiator: queues read/write commands in a small FIFO and replays them as
// SETUP/ACCESS transfers, returning one response pulse per command.
module apb_cmd_master #(
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int FIFO_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [AMBA_WORD-1:0]       cmd_wdata,
    output logic                       rsp_valid,
    output logic [AMBA_WORD-1:0]       rsp_rdata,
    output logic                       rsp_err,
    output logic                       busy,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic [AMBA_WORD-1:0]       PWDATA,
    output logic                       PWRITE,
    output logic                       PSEL,
    output logic                       PENABLE,
    input  logic [AMBA_WORD-1:0]       PRDATA,
    input  logic                       PREADY
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 1 + AMBA_ADDR_WIDTH + AMBA_WORD;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    state_t                     state_q, state_d;
    logic [ENT_W-1:0]           fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       rdy_en_q, rdy_en_d;
    logic [AMBA_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [AMBA_WORD-1:0]       pwdata_q, pwdata_d;
    logic                       pwrite_q, pwrite_d;
    logic                       psel_q, psel_d;
    logic                       penable_q, penable_d;
    logic [TMO_W-1:0]           tmo_q, tmo_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic [AMBA_WORD-1:0]       rsp_rdata_q, rsp_rdata_d;
    logic                       rsp_err_q, rsp_err_d;

    logic                       full, empty, push, pop, load, done;
    logic [ENT_W-1:0]           head;
    logic                       head_write;
    logic [AMBA_ADDR_WIDTH-1:0] head_addr;
    logic [AMBA_WORD-1:0]       head_wdata;

    assign full       = (count_q == CNT_FULL);
    assign empty      = (count_q == '0);
    // Ready is held off until the first edge after reset releases.
    assign cmd_ready  = rdy_en_q & ~full;
    assign push       = cmd_valid & cmd_ready;
    assign head       = fifo_mem[rd_ptr_q];
    assign head_write = head[ENT_W-1];
    assign head_addr  = head[ENT_W-2 -: AMBA_ADDR_WIDTH];
    assign head_wdata = head[AMBA_WORD-1:0];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        tmo_d       = tmo_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        load        = 1'b0;
        done        = 1'b0;
        rdy_en_d    = 1'b1;
        case (state_q)
            S_IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                load      = ~empty;
            end
            S_SETUP: begin
                state_d   = S_ACCESS;
                penable_d = 1'b1;
            end
            S_ACCESS: begin
                if (PREADY) begin
                    done        = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
                    done        = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
                if (done) begin
                    tmo_d = '0;
                    if (!empty) begin
                        load = 1'b1;
                    end else begin
                        state_d   = S_IDLE;
                        psel_d    = 1'b0;
                        penable_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Popping the head straight into the address/data registers doubles as
        // the registered FIFO read, so SETUP always sees stable bus values.
        if (load) begin
            state_d   = S_SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = head_write;
            paddr_d   = head_addr;
            pwdata_d  = head_write ? head_wdata : '0;
        end
        pop      = load;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rdy_en_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            tmo_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rdy_en_q    <= rdy_en_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            tmo_q       <= tmo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign busy      = ~empty | (state_q != S_IDLE);
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PWRITE    = pwrite_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
module tb_apb_cmd_master;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cmd_valid, cmd_write, cmd_ready;
    logic [19:0] cmd_addr, paddr;
    logic [31:0] cmd_wdata, rsp_rdata, pwdata, prdata, prdata_val;
    logic        rsp_valid, rsp_err, busy, pwrite, psel, penable, pready, echo;

    int n_cmp = 0;
    int n_err = 0;

    assign prdata = echo ? ({12'h000, paddr} | 32'hC0DE0000) : prdata_val;

    apb_cmd_master dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .PADDR     (paddr),
        .PWDATA    (pwdata),
        .PWRITE    (pwrite),
        .PSEL      (psel),
        .PENABLE   (penable),
        .PRDATA    (prdata),
        .PREADY    (pready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input bit ok, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end else begin
            $display("PASS %s: observed=%0h", tag, obs);
        end
    endtask

    task automatic drive_cmd(input logic w, input logic [19:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [6:0]  t3_psel, t3_pen, t3_rsp;
    logic [19:0] t3_addr [7];
    logic [31:0] t3_rdata [7];
    logic [31:0] got_q [$];
    logic [31:0] ord_v;
    logic        got, err_s, psel_s;
    logic [31:0] rdata_s;
    int          acc_cnt, rsp_cnt, psel_cnt, gsz;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        pready = 1'b1; echo = 1'b0; prdata_val = '0;

        repeat (3) tick();
        check("rst_psel", psel === 1'b0, psel, 1'b0);
        check("rst_penable", penable === 1'b0, penable, 1'b0);
        check("rst_rsp_valid", rsp_valid === 1'b0, rsp_valid, 1'b0);
        check("rst_busy", busy === 1'b0, busy, 1'b0);
        check("rst_cmd_ready", cmd_ready === 1'b0, cmd_ready, 1'b0);
        check("rst_paddr", paddr === 20'h0, paddr, 20'h0);
        rst = 1'b0;
        tick();
        check("rst_ready_after", cmd_ready === 1'b1, cmd_ready, 1'b1);
        $display("reset: done");

        drive_cmd(1'b1, 20'h4, 32'hDEADBEEF);
        tick();
        cmd_valid = 1'b0;
        check("t1_n_psel", psel === 1'b0, psel, 1'b0);
        check("t1_n_busy", busy === 1'b1, busy, 1'b1);
        tick();
        check("t1_setup_psel", psel === 1'b1, psel, 1'b1);
        check("t1_setup_pen", penable === 1'b0, penable, 1'b0);
        check("t1_pwrite", pwrite === 1'b1, pwrite, 1'b1);
        check("t1_paddr", paddr === 20'h4, paddr, 20'h4);
        check("t1_pwdata", pwdata === 32'hDEADBEEF, pwdata, 32'hDEADBEEF);
        tick();
        check("t1_acc_psel", psel === 1'b1, psel, 1'b1);
        check("t1_acc_pen", penable === 1'b1, penable, 1'b1);
        check("t1_acc_rsp", rsp_valid === 1'b0, rsp_valid, 1'b0);
        tick();
        check("t1_rsp_valid", rsp_valid === 1'b1, rsp_valid, 1'b1);
        check("t1_rsp_err", rsp_err === 1'b0, rsp_err, 1'b0);
        check("t1_rsp_rdata", rsp_rdata === 32'h0, rsp_rdata, 32'h0);
        check("t1_idle_psel", psel === 1'b0, psel, 1'b0);
        tick();
        check("t1_rsp_once", rsp_valid === 1'b0, rsp_valid, 1'b0);
        check("t1_busy_end", busy === 1'b0, busy, 1'b0);
        $display("write 0x4: done");

        prdata_val = 32'h0000A5A5;
        drive_cmd(1'b0, 20'h10, 32'h12345678);
        tick();
        cmd_valid = 1'b0;
        tick();
        check("t2_psel", psel === 1'b1, psel, 1'b1);
        check("t2_pwrite", pwrite === 1'b0, pwrite, 1'b0);
        check("t2_pwdata", pwdata === 32'h0, pwdata, 32'h0);
        check("t2_paddr", paddr === 20'h10, paddr, 20'h10);
        tick();
        check("t2_pen", penable === 1'b1, penable, 1'b1);
        tick();
        check("t2_rsp_valid", rsp_valid === 1'b1, rsp_valid, 1'b1);
        check("t2_rsp_rdata", rsp_rdata === 32'h0000A5A5, rsp_rdata, 32'h0000A5A5);
        check("t2_rsp_err", rsp_err === 1'b0, rsp_err, 1'b0);
        tick();
        check("t2_rsp_once", rsp_valid === 1'b0, rsp_valid, 1'b0);
        $display("read 0x10: done");

        echo = 1'b1;
        t3_psel = 7'b0111111;
        t3_pen  = 7'b0101010;
        t3_rsp  = 7'b1010100;
        t3_addr[0] = 20'h100; t3_addr[2] = 20'h200; t3_addr[4] = 20'h300;
        t3_rdata[2] = 32'h0; t3_rdata[4] = 32'hC0DE0200; t3_rdata[6] = 32'h0;
        for (int k = 0; k < 8; k++) begin
            if (k == 0)      drive_cmd(1'b1, 20'h100, 32'h11111111);
            else if (k == 1) drive_cmd(1'b0, 20'h200, 32'h0);
            else if (k == 2) drive_cmd(1'b1, 20'h300, 32'h33333333);
            else             cmd_valid = 1'b0;
            tick();
            if (k >= 1) begin
                check("t3_psel", psel === t3_psel[k-1], psel, t3_psel[k-1]);
                check("t3_penable", penable === t3_pen[k-1], penable, t3_pen[k-1]);
                check("t3_rsp_valid", rsp_valid === t3_rsp[k-1], rsp_valid, t3_rsp[k-1]);
                if (k == 1 || k == 3 || k == 5)
                    check("t3_paddr", paddr === t3_addr[k-1], paddr, t3_addr[k-1]);
                if (k == 3 || k == 5 || k == 7)
                    check("t3_rdata", rsp_rdata === t3_rdata[k-1], rsp_rdata, t3_rdata[k-1]);
            end
        end
        $display("three queued: done");

        pready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_cmd(1'b0, 20'(17 + k), 32'h0);
            check("t4_ready_push", cmd_ready === 1'b1, cmd_ready, 1'b1);
            tick();
        end
        cmd_valid = 1'b0;
        check("t4_full_ready", cmd_ready === 1'b0, cmd_ready, 1'b0);
        check("t4_stall_pen", penable === 1'b1, penable, 1'b1);
        tick();
        check("t4_full_ready2", cmd_ready === 1'b0, cmd_ready, 1'b0);
        pready = 1'b1;
        tick();
        check("t4_ready_after_pop", cmd_ready === 1'b1, cmd_ready, 1'b1);
        check("t4_first_rsp", rsp_valid === 1'b1, rsp_valid, 1'b1);
        got_q.delete();
        if (rsp_valid) got_q.push_back(rsp_rdata);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rsp_valid) got_q.push_back(rsp_rdata);
        end
        gsz = got_q.size();
        check("t4_rsp_count", gsz === 5, gsz, 5);
        for (int i = 0; i < 5; i++) begin
            ord_v = (i < got_q.size()) ? got_q[i] : 32'hXXXXXXXX;
            check("t4_rsp_order", ord_v === 32'hC0DE0011 + 32'(i), ord_v, 32'hC0DE0011 + 32'(i));
        end
        check("t4_busy_end", busy === 1'b0, busy, 1'b0);
        $display("fifo full: %0d responses", got_q.size());

        pready = 1'b0;
        drive_cmd(1'b1, 20'h50, 32'h55);
        tick();
        cmd_valid = 1'b0;
        repeat (5) tick();
        check("t5_wait_pen", penable === 1'b1, penable, 1'b1);
        check("t5_wait_rsp", rsp_valid === 1'b0, rsp_valid, 1'b0);
        pready = 1'b1;
        tick();
        check("t5_rsp_valid", rsp_valid === 1'b1, rsp_valid, 1'b1);
        check("t5_rsp_err", rsp_err === 1'b0, rsp_err, 1'b0);
        tick();
        check("t5_rsp_once", rsp_valid === 1'b0, rsp_valid, 1'b0);
        $display("wait states: done");

        pready = 1'b0;
        drive_cmd(1'b0, 20'h60, 32'h0);
        tick();
        cmd_valid = 1'b0;
        got = 1'b0; acc_cnt = 0; err_s = 1'b0; rdata_s = '1; psel_s = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (rsp_valid) begin
                got = 1'b1; err_s = rsp_err; rdata_s = rsp_rdata; psel_s = psel;
            end else if (penable) begin
                acc_cnt++;
            end
        end
        check("t5_tmo_got", got === 1'b1, got, 1'b1);
        check("t5_tmo_cycles", acc_cnt === 16, acc_cnt, 16);
        check("t5_tmo_err", err_s === 1'b1, err_s, 1'b1);
        check("t5_tmo_rdata", rdata_s === 32'h0, rdata_s, 32'h0);
        check("t5_tmo_psel", psel_s === 1'b0, psel_s, 1'b0);
        $display("timeout: %0d access cycles", acc_cnt);

        drive_cmd(1'b1, 20'h70, 32'h7);
        tick();
        drive_cmd(1'b1, 20'h71, 32'h8);
        tick();
        drive_cmd(1'b1, 20'h72, 32'h9);
        tick();
        cmd_valid = 1'b0;
        tick();
        check("t6_pre_pen", penable === 1'b1, penable, 1'b1);
        check("t6_pre_busy", busy === 1'b1, busy, 1'b1);
        rst = 1'b1;
        tick();
        check("t6_psel", psel === 1'b0, psel, 1'b0);
        check("t6_penable", penable === 1'b0, penable, 1'b0);
        check("t6_busy", busy === 1'b0, busy, 1'b0);
        check("t6_rsp_valid", rsp_valid === 1'b0, rsp_valid, 1'b0);
        check("t6_ready_in_rst", cmd_ready === 1'b0, cmd_ready, 1'b0);
        rst = 1'b0;
        pready = 1'b1;
        tick();
        check("t6_ready_after", cmd_ready === 1'b1, cmd_ready, 1'b1);
        rsp_cnt = 0; psel_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rsp_valid) rsp_cnt++;
            if (psel) psel_cnt++;
        end
        check("t6_no_rsp", rsp_cnt === 0, rsp_cnt, 0);
        check("t6_no_psel", psel_cnt === 0, psel_cnt, 0);
        $display("reset mid-access: done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
